// File: rtl/opc7_bus_arbiter.sv
// opc7_bus_arbiter: shares one memory/IO port between the opc7 CPU and a DMA requester,
// stalling the CPU through clken and bounding DMA wait with a CPU slot counter.
module opc7_bus_arbiter #(
  parameter int AW = 20,
  parameter int DW = 32,
  parameter int CPU_SLOTS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_dout,
  input  logic          cpu_rnw,
  input  logic          cpu_vpa,
  input  logic          cpu_vda,
  input  logic          cpu_vio,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_clken,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_rnw,
  output logic          dma_gnt,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_ce,
  output logic          mem_we,
  output logic          mem_io,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);
  typedef enum logic [2:0] {ARB, CPU_ACC, CPU_DONE, DMA_ACC, DMA_DONE} state_t;
  state_t state;
  logic [7:0] slot_cnt;
  logic boot;
  logic cpu_busreq, full, dma_wins, acc_cpu, acc_dma;
  assign cpu_busreq = cpu_vpa | cpu_vda | cpu_vio;
  assign full       = slot_cnt == 8'(CPU_SLOTS);
  assign dma_wins   = dma_req & (!cpu_busreq | full);
  assign acc_cpu    = state == CPU_ACC;
  assign acc_dma    = state == DMA_ACC;
  assign mem_addr   = acc_dma ? dma_addr : cpu_address;
  assign mem_wdata  = acc_dma ? dma_wdata : cpu_dout;
  assign mem_ce     = acc_cpu | acc_dma;
  assign mem_we     = (acc_cpu & !cpu_rnw) | (acc_dma & !dma_rnw);
  assign mem_io     = acc_cpu & cpu_vio;
  assign dma_gnt    = acc_dma;
  assign dma_ack    = state == DMA_DONE;
  // boot keeps clken high through reset and spends the first edge after release idling in ARB
  assign cpu_clken  = (state == CPU_DONE) | boot;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB;
      slot_cnt  <= '0;
      boot      <= 1'b1;
      cpu_din   <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        ARB: begin
          boot <= 1'b0;
          if (!boot) begin
            state    <= dma_wins ? DMA_ACC : cpu_busreq ? CPU_ACC : CPU_DONE;
            slot_cnt <= (!dma_req || dma_wins) ? 8'd0 : (cpu_busreq && !full) ? slot_cnt + 8'd1 : slot_cnt;
          end
        end
        CPU_ACC: if (mem_ready) begin
          state <= CPU_DONE;
          if (cpu_rnw) cpu_din <= mem_rdata;
        end
        DMA_ACC: if (mem_ready) begin
          state     <= DMA_DONE;
          dma_rdata <= mem_rdata;
        end
        default: state <= ARB;
      endcase
    end
  end
endmodule
